// File: rtl/charmap_pkg.sv
// Shared constants and types for the character-RAM arbiter: screen geometry,
// control character codes and the arbiter state encoding.
package charmap_pkg;

   localparam int unsigned COLS = 80;
   localparam int unsigned ROWS = 60;

   localparam logic [7:0] CHAR_NL = 8'h0A;
   localparam logic [7:0] CHAR_FF = 8'h0C;
   localparam logic [7:0] CHAR_SP = 8'h20;

   typedef enum logic {
      IDLE,
      CLEAR
   } arb_state_t;

endpackage

// File: rtl/charmap_arbiter_if.sv
// Bundle of CPU write, VGA read, char RAM port and status signals around the arbiter.
// The slave modport is the arbiter's view; master is its surroundings.
interface charmap_arbiter_if #(
   parameter int ADDR_W = 13
);
   logic              cpu_wr_valid;
   logic [7:0]        cpu_wr_char;
   logic              cpu_wr_ready;
   logic              cpu_cur_set;
   logic [ADDR_W-1:0] cpu_cur_pos;

   logic              vga_rd_req;
   logic [ADDR_W-1:0] vga_rd_addr;
   logic              vga_rd_valid;
   logic [7:0]        vga_rd_char;

   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_wdata;
   logic [7:0]        ram_rdata;

   logic [ADDR_W-1:0] cursor;
   logic              busy;

   modport slave (
      input  cpu_wr_valid, cpu_wr_char, cpu_cur_set, cpu_cur_pos,
      input  vga_rd_req, vga_rd_addr, ram_rdata,
      output cpu_wr_ready, vga_rd_valid, vga_rd_char,
      output ram_en, ram_we, ram_addr, ram_wdata, cursor, busy
   );

   modport master (
      output cpu_wr_valid, cpu_wr_char, cpu_cur_set, cpu_cur_pos,
      output vga_rd_req, vga_rd_addr, ram_rdata,
      input  cpu_wr_ready, vga_rd_valid, vga_rd_char,
      input  ram_en, ram_we, ram_addr, ram_wdata, cursor, busy
   );

endinterface

// File: rtl/char_fifo.sv
// Small synchronous FIFO with first-word fall-through head, used to buffer CPU characters.
// DEPTH must be a power of two so the pointers wrap on their own.
module char_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == (PTR_W + 1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_reg[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
            2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/charmap_arbiter.sv
// Single-port char RAM owner: VGA reads win the port, then the clear sweep, then buffered
// CPU characters. Tracks the text cursor and handles newline / form-feed.
module charmap_arbiter
   import charmap_pkg::*;
#(
   parameter int ADDR_W     = 13,
   parameter int FIFO_DEPTH = 4
) (
   input logic               clk,
   input logic               reset,
   charmap_arbiter_if.slave  bus
);
   localparam int unsigned       CELLS     = COLS * ROWS;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
   localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(ROWS - 1);

   arb_state_t        state_reg;
   logic [ADDR_W-1:0] cursor_reg;
   logic [ADDR_W-1:0] cursor_next;
   logic [ADDR_W-1:0] clr_addr_reg;
   logic              vga_valid_reg;

   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic [7:0]        head_char;

   logic              grant_vga;
   logic              grant_clear;
   logic              grant_pop;
   logic              head_is_nl;
   logic              head_is_ff;

   logic [ADDR_W-1:0] cursor_row;
   logic [ADDR_W-1:0] cursor_inc;
   logic [ADDR_W-1:0] row_next;
   logic [ADDR_W-1:0] cur_load;

   assign fifo_push = bus.cpu_wr_valid && !fifo_full;

   char_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .srst  (reset),
      .push  (fifo_push),
      .din   (bus.cpu_wr_char),
      .pop   (fifo_pop),
      .dout  (head_char),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign grant_vga   = bus.vga_rd_req;
   assign grant_clear = !grant_vga && (state_reg == CLEAR);
   assign grant_pop   = !grant_vga && (state_reg == IDLE) && !fifo_empty;
   assign fifo_pop    = grant_pop;
   assign head_is_nl  = (head_char == CHAR_NL);
   assign head_is_ff  = (head_char == CHAR_FF);

   // Control characters consume a pop but never touch the RAM port.
   always_comb begin
      bus.ram_en    = 1'b0;
      bus.ram_we    = 1'b0;
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      if (grant_vga) begin
         bus.ram_en   = 1'b1;
         bus.ram_addr = bus.vga_rd_addr;
      end else if (grant_clear) begin
         bus.ram_en    = 1'b1;
         bus.ram_we    = 1'b1;
         bus.ram_addr  = clr_addr_reg;
         bus.ram_wdata = CHAR_SP;
      end else if (grant_pop && !head_is_nl && !head_is_ff) begin
         bus.ram_en    = 1'b1;
         bus.ram_we    = 1'b1;
         bus.ram_addr  = cursor_reg;
         bus.ram_wdata = head_char;
      end
   end

   assign cursor_row = ADDR_W'(32'(cursor_reg) / COLS);
   assign cursor_inc = (cursor_reg == LAST_ADDR) ? '0 : cursor_reg + ADDR_W'(1);
   assign row_next   = (cursor_row == LAST_ROW) ? '0
                                                : ADDR_W'((32'(cursor_row) + 32'd1) * COLS);
   assign cur_load   = (32'(bus.cpu_cur_pos) >= CELLS) ? '0 : bus.cpu_cur_pos;

   // An explicit CPU cursor load overrides whatever the popped character would do.
   always_comb begin
      cursor_next = cursor_reg;
      if (bus.cpu_cur_set) begin
         cursor_next = cur_load;
      end else if (grant_pop) begin
         if (head_is_nl) begin
            cursor_next = row_next;
         end else if (head_is_ff) begin
            cursor_next = '0;
         end else begin
            cursor_next = cursor_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         clr_addr_reg  <= '0;
         cursor_reg    <= '0;
         vga_valid_reg <= 1'b0;
      end else begin
         cursor_reg    <= cursor_next;
         vga_valid_reg <= grant_vga;
         case (state_reg)
            IDLE: begin
               if (grant_pop && head_is_ff) begin
                  state_reg    <= CLEAR;
                  clr_addr_reg <= '0;
               end
            end
            CLEAR: begin
               if (grant_clear) begin
                  if (clr_addr_reg == LAST_ADDR) begin
                     state_reg    <= IDLE;
                     clr_addr_reg <= '0;
                  end else begin
                     clr_addr_reg <= clr_addr_reg + ADDR_W'(1);
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.cursor       = cursor_reg;
   assign bus.vga_rd_valid = vga_valid_reg;
   assign bus.vga_rd_char  = vga_valid_reg ? bus.ram_rdata : 8'h00;
   assign bus.cpu_wr_ready = !fifo_full;
   assign bus.busy         = (state_reg == CLEAR) || !fifo_empty;

endmodule

// File: tb/tb_charmap_arbiter.sv
// Scoreboard bench for charmap_arbiter: a behavioural RAM and cursor model predict every
// RAM write; a negedge monitor records port activity for the test tasks to compare.
module tb_charmap_arbiter;

   localparam int AW = 13;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [7:0]    data;
      int            cyc;
   } acc_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } vld_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   acc_t obs_acc[$];
   vld_t obs_vld[$];
   exp_t exp_q[$];
   int   acc_rd = 0;
   int   vld_rd = 0;
   int   m_cursor = 0;
   logic [7:0] mem [0:(1<<AW)-1];

   charmap_arbiter_if #(.ADDR_W(AW)) bus ();

   charmap_arbiter #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #20 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous RAM, one-cycle read latency
   always @(posedge clk) begin
      if (bus.ram_en === 1'b1 && bus.ram_we === 1'b1) mem[bus.ram_addr] <= bus.ram_wdata;
      if (bus.ram_en === 1'b1 && bus.ram_we === 1'b0) bus.ram_rdata <= mem[bus.ram_addr];
   end

   always @(negedge clk) begin
      if (bus.ram_en === 1'b1)
         obs_acc.push_back('{we: bus.ram_we, addr: bus.ram_addr, data: bus.ram_wdata, cyc: cyc});
      if (bus.vga_rd_valid === 1'b1)
         obs_vld.push_back('{data: bus.vga_rd_char, cyc: cyc});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic get_acc(output acc_t o, output bit ok);
      ok = 1'b0;
      o = '{we: 1'b0, addr: '0, data: '0, cyc: 0};
      for (int i = 0; i < 40 && !ok; i++) begin
         if (acc_rd < obs_acc.size()) begin
            o = obs_acc[acc_rd];
            acc_rd++;
            ok = 1'b1;
         end else begin
            tick();
         end
      end
   endtask

   task automatic model_char(input logic [7:0] ch);
      if (ch == 8'h0A) begin
         m_cursor = (m_cursor / 80 + 1) * 80;
         if (m_cursor >= 4800) m_cursor = 0;
      end else if (ch == 8'h0C) begin
         for (int a = 0; a < 4800; a++) exp_q.push_back('{addr: AW'(a), data: 8'h20});
         m_cursor = 0;
      end else begin
         exp_q.push_back('{addr: AW'(m_cursor), data: ch});
         m_cursor = (m_cursor == 4799) ? 0 : m_cursor + 1;
      end
   endtask

   task automatic cpu_push(input logic [7:0] ch);
      bus.cpu_wr_valid = 1'b1;
      bus.cpu_wr_char  = ch;
      for (int i = 0; i < 200 && bus.cpu_wr_ready !== 1'b1; i++) tick();
      n_checks++;
      if (bus.cpu_wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL push_ready: cpu_wr_ready=%b, required 1 within 200 cycles", bus.cpu_wr_ready);
      end
      tick();
      bus.cpu_wr_valid = 1'b0;
      model_char(ch);
   endtask

   task automatic set_cursor(input int pos);
      bus.cpu_cur_set = 1'b1;
      bus.cpu_cur_pos = AW'(pos);
      tick();
      bus.cpu_cur_set = 1'b0;
      m_cursor = (pos >= 4800) ? 0 : pos;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.cpu_wr_valid = 1'b0;
      bus.cpu_wr_char  = 8'h00;
      bus.cpu_cur_set  = 1'b0;
      bus.cpu_cur_pos  = '0;
      bus.vga_rd_req   = 1'b0;
      bus.vga_rd_addr  = '0;
      repeat (3) tick();
      n_checks++;
      if (bus.cursor !== 13'd0) begin n_fail++; $display("FAIL reset_cursor: got %0d, required 0", bus.cursor); end
      n_checks++;
      if (bus.cpu_wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", bus.cpu_wr_ready); end
      n_checks++;
      if (bus.ram_en !== 1'b0 || bus.ram_we !== 1'b0) begin
         n_fail++; $display("FAIL reset_ram: en=%b we=%b, required 0 0", bus.ram_en, bus.ram_we);
      end
      n_checks++;
      if (bus.busy !== 1'b0 || bus.vga_rd_valid !== 1'b0 || bus.vga_rd_char !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_status: busy=%b valid=%b char=%h, required 0 0 00",
                  bus.busy, bus.vga_rd_valid, bus.vga_rd_char);
      end
      reset = 1'b0;
      tick();
      m_cursor = 0;
      acc_rd = obs_acc.size();
      $display("test_reset done");
   endtask

   task automatic test_write();
      acc_t o;
      exp_t e;
      bit   ok;
      int   c[2];
      int   j;
      cpu_push(8'h41);
      cpu_push(8'h42);
      j = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         get_acc(o, ok);
         n_checks++;
         if (!ok || o.we !== 1'b1 || o.addr !== e.addr || o.data !== e.data) begin
            n_fail++;
            $display("FAIL t1_write: ok=%0d we=%b addr=%0d data=%h, required addr=%0d data=%h",
                     ok, o.we, o.addr, o.data, e.addr, e.data);
            if (!ok) exp_q.delete();
         end
         if (j < 2) c[j] = o.cyc;
         j++;
      end
      n_checks++;
      if (c[1] != c[0] + 1) begin n_fail++; $display("FAIL t1_consecutive: cycles %0d,%0d, required adjacent", c[0], c[1]); end
      repeat (2) tick();
      n_checks++;
      if (bus.cursor !== 13'd2) begin n_fail++; $display("FAIL t1_cursor: got %0d, required 2", bus.cursor); end
      $display("test_write: 2 writes, cursor=%0d", bus.cursor);
   endtask

   task automatic test_newline();
      set_cursor(5);
      acc_rd = obs_acc.size();
      cpu_push(8'h0A);
      repeat (3) tick();
      n_checks++;
      if (obs_acc.size() != acc_rd) begin
         n_fail++; $display("FAIL t2_nl_access: %0d RAM accesses, required 0", obs_acc.size() - acc_rd);
      end
      n_checks++;
      if (bus.cursor !== 13'd80) begin n_fail++; $display("FAIL t2_nl_cursor: got %0d, required 80", bus.cursor); end
      set_cursor(4790);
      cpu_push(8'h0A);
      repeat (3) tick();
      n_checks++;
      if (bus.cursor !== 13'd0) begin n_fail++; $display("FAIL t2_nl_wrap: got %0d, required 0", bus.cursor); end
      $display("test_newline: cursor=%0d", bus.cursor);
   endtask

   task automatic test_vga_priority();
      acc_t o;
      exp_t e;
      vld_t v;
      bit   ok;
      bit   took;
      int   accepted;
      int   rc[10];
      set_cursor(18);
      cpu_push(8'h51);
      repeat (3) tick();
      exp_q.delete();
      set_cursor(32);
      acc_rd = obs_acc.size();
      vld_rd = obs_vld.size();
      accepted = 0;
      for (int i = 0; i < 10; i++) begin
         bus.vga_rd_req  = 1'b1;
         bus.vga_rd_addr = AW'(18);
         bus.cpu_wr_valid = (accepted < 6);
         bus.cpu_wr_char  = 8'h61 + 8'(accepted);
         took = bus.cpu_wr_valid && (bus.cpu_wr_ready === 1'b1);
         tick();
         if (took) begin
            model_char(bus.cpu_wr_char);
            accepted++;
         end
      end
      n_checks++;
      if (accepted != 4 || bus.cpu_wr_ready !== 1'b0) begin
         n_fail++; $display("FAIL t3_backpressure: accepted=%0d ready=%b, required 4 0", accepted, bus.cpu_wr_ready);
      end
      bus.cpu_wr_valid = 1'b0;
      bus.vga_rd_req   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         get_acc(o, ok);
         rc[i] = o.cyc;
         n_checks++;
         if (!ok || o.we !== 1'b0 || o.addr !== 13'd18) begin
            n_fail++; $display("FAIL t3_read: ok=%0d we=%b addr=%0d, required read at 18", ok, o.we, o.addr);
         end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         get_acc(o, ok);
         n_checks++;
         if (!ok || o.we !== 1'b1 || o.addr !== e.addr || o.data !== e.data) begin
            n_fail++;
            $display("FAIL t3_write: ok=%0d we=%b addr=%0d data=%h, required addr=%0d data=%h",
                     ok, o.we, o.addr, o.data, e.addr, e.data);
            if (!ok) exp_q.delete();
         end
      end
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (vld_rd >= obs_vld.size()) begin
            n_fail++; $display("FAIL t3_valid: read %0d produced no vga_rd_valid", i);
         end else begin
            v = obs_vld[vld_rd];
            vld_rd++;
            if (v.data !== 8'h51 || v.cyc != rc[i] + 1) begin
               n_fail++;
               $display("FAIL t3_valid: char=%h cycle=%0d, required 51 at cycle %0d", v.data, v.cyc, rc[i] + 1);
            end
         end
      end
      $display("test_vga_priority: accepted=%0d cursor=%0d", accepted, bus.cursor);
   endtask

   task automatic test_form_feed();
      acc_t o;
      exp_t e;
      bit   ok;
      acc_rd = obs_acc.size();
      cpu_push(8'h0C);
      repeat (5) tick();
      n_checks++;
      if (bus.busy !== 1'b1 || bus.cursor !== 13'd0) begin
         n_fail++; $display("FAIL t4_sweep_state: busy=%b cursor=%0d, required 1 0", bus.busy, bus.cursor);
      end
      cpu_push(8'h5A);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         get_acc(o, ok);
         n_checks++;
         if (!ok || o.we !== 1'b1 || o.addr !== e.addr || o.data !== e.data) begin
            n_fail++;
            $display("FAIL t4_write: ok=%0d we=%b addr=%0d data=%h, required addr=%0d data=%h",
                     ok, o.we, o.addr, o.data, e.addr, e.data);
            if (!ok) exp_q.delete();
         end
      end
      repeat (2) tick();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.cursor !== 13'd1) begin
         n_fail++; $display("FAIL t4_after: busy=%b cursor=%0d, required 0 1", bus.busy, bus.cursor);
      end
      $display("test_form_feed: sweep done, cursor=%0d", bus.cursor);
   endtask

   task automatic test_cursor_wrap();
      acc_t o;
      exp_t e;
      bit   ok;
      set_cursor(4799);
      acc_rd = obs_acc.size();
      cpu_push(8'h58);
      cpu_push(8'h59);
      set_cursor(100);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         get_acc(o, ok);
         n_checks++;
         if (!ok || o.we !== 1'b1 || o.addr !== e.addr || o.data !== e.data) begin
            n_fail++;
            $display("FAIL t5_write: ok=%0d we=%b addr=%0d data=%h, required addr=%0d data=%h",
                     ok, o.we, o.addr, o.data, e.addr, e.data);
            if (!ok) exp_q.delete();
         end
      end
      repeat (2) tick();
      n_checks++;
      if (bus.cursor !== 13'd100) begin n_fail++; $display("FAIL t5_curset_pop: got %0d, required 100", bus.cursor); end
      set_cursor(5000);
      n_checks++;
      if (bus.cursor !== 13'd0) begin n_fail++; $display("FAIL t5_curset_range: got %0d, required 0", bus.cursor); end
      $display("test_cursor_wrap: cursor=%0d", bus.cursor);
   endtask

   task automatic test_reset_mid_clear();
      bit found;
      bus.cpu_wr_valid = 1'b1;
      bus.cpu_wr_char  = 8'h0C;
      tick();
      bus.cpu_wr_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
         if (bus.ram_we === 1'b1 && bus.ram_addr === 13'd1234) found = 1'b1;
         else tick();
      end
      n_checks++;
      if (!found) begin n_fail++; $display("FAIL t6_reach_1234: clear write at 1234 not seen within 3000 cycles"); end
      bus.vga_rd_req   = 1'b1;
      bus.vga_rd_addr  = AW'(5);
      bus.cpu_wr_valid = 1'b1;
      bus.cpu_wr_char  = 8'h57;
      reset = 1'b1;
      tick();
      bus.vga_rd_req   = 1'b0;
      bus.cpu_wr_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.ram_en !== 1'b0 || bus.cursor !== 13'd0) begin
         n_fail++; $display("FAIL t6_port: ram_en=%b cursor=%0d, required 0 0", bus.ram_en, bus.cursor);
      end
      n_checks++;
      if (bus.busy !== 1'b0 || bus.cpu_wr_ready !== 1'b1 || bus.vga_rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL t6_state: busy=%b ready=%b valid=%b, required 0 1 0",
                  bus.busy, bus.cpu_wr_ready, bus.vga_rd_valid);
      end
      reset = 1'b0;
      tick();
      $display("test_reset_mid_clear: busy=%b cursor=%0d", bus.busy, bus.cursor);
   endtask

   initial begin
      test_reset();
      test_write();
      test_newline();
      test_vga_priority();
      test_form_feed();
      test_cursor_wrap();
      test_reset_mid_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
